uart_frame_controller: RTL
==========================

Name: uart_frame_controller

Overview:
- Parametrised successor of the 2x16-bit UART operand controller. Collects NUM_OPS operands of OP_BYTES bytes each from the RX UART interface and gates the datapath while it computes.
- Once the datapath signals a valid result, it streams RES_BYTES result bytes to the TX UART interface.
- Sits between the UART RX/TX interfaces and the arithmetic core. Drives per-byte input-memory load strobes and the result byte select.

Parameters:
- OP_BYTES, 2, bytes per operand (>=1).
- NUM_OPS, 2, operands per frame (>=1).
- RES_BYTES, 2, result bytes returned per frame (>=1).
- TIMEOUT_CYC, 1000000, inter-byte RX timeout in cycles. Used only with RX_TIMEOUT_EN.
- Derived: IN_BYTES = NUM_OPS*OP_BYTES.
- Derived: SEL_W = max(1, clog2(RES_BYTES)).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Rx_DV_in  in  1  one-cycle pulse per received byte.
- Tx_Done_in  in  1  one-cycle pulse when TX UART finishes a byte.
- c_valid_in  in  1  datapath result valid.
- En_out  out  1  datapath enable.
- Load_en_out  out  IN_BYTES  one-hot input-memory byte strobe.
- Tx_DV_out  out  1  one-cycle TX request pulse.
- Tx_Byte_sel_out  out  SEL_W  result byte index, 0 = MSB.
- Busy_out  out  1  high when state != IDLE.
- Rx_ovr_out  out  1  one-cycle pulse when Rx_DV_in arrives in EXE/SEND.
- Timeout_out  out  1  one-cycle pulse on RX timeout.

Behaviour:
- Reset values (RST=1, asynchronous): state=IDLE, load_cnt=0, send_cnt=0, pending=0. All outputs 0.
- States are IDLE, LOAD, EXE, SEND.
- Byte ordering: frame byte k belongs to operand k/OP_BYTES, MSB first within each operand. Result bytes are also sent MSB first.
- Load_en_out[k] is combinational: high when Rx_DV_in=1, state is IDLE or LOAD, and load_cnt==k. At most one bit is high at a time.
- IDLE: on Rx_DV_in, load_cnt becomes 1 and the next state is LOAD. If IN_BYTES==1, the next state is EXE directly.
- LOAD: each Rx_DV_in increments load_cnt. Rx_DV_in while load_cnt==IN_BYTES-1 moves to EXE next cycle and clears load_cnt.
- Latency: last byte strobe at cycle t -> En_out=1 at t+1.
- EXE: En_out=1 for every cycle in EXE. On c_valid_in=1 the next state is SEND. c_valid_in outside EXE is ignored.
- SEND:
  - Tx_DV_out is registered. It pulses on the first cycle in SEND (c_valid_in at u -> Tx_DV_out at u+1) with Tx_Byte_sel_out=0, and sets pending=1.
  - Tx_Done_in with pending=1 and send_cnt<RES_BYTES-1: send_cnt increments and Tx_DV_out pulses on the next cycle with the new select value.
  - Tx_Done_in with pending=1 and send_cnt==RES_BYTES-1: next state IDLE, send_cnt=0, pending=0, no pulse.
  - Tx_Done_in with pending=0, or in any other state, is ignored.
- Tx_Byte_sel_out equals send_cnt and is stable between a Tx_DV_out pulse and its matching Tx_Done_in.
- Rx_DV_in during EXE/SEND: no load strobe, no state change, Rx_ovr_out pulses in the same cycle (combinational).
- Simultaneous Tx_Done_in (last byte) and Rx_DV_in in SEND: Rx_ovr_out pulses and the byte is dropped. The next frame starts from IDLE.
- Counter widths must hold IN_BYTES-1 and RES_BYTES-1 without wrap. Illegal state encodings recover to IDLE.
- RST asserted mid-frame aborts immediately. Partial loads are discarded and no TX pulse is issued.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- With the macro: a TIMEOUT_CYC-wide idle counter runs only in LOAD and clears on every Rx_DV_in.
  - When it reaches TIMEOUT_CYC-1 with no Rx_DV_in, the block returns to IDLE next cycle, clears load_cnt, and pulses Timeout_out for one cycle.
  - Rx_DV_in on that same cycle takes priority: the byte is accepted and there is no timeout.
- Without the macro: Timeout_out is tied 0, there is no counter, and LOAD waits indefinitely.

Test Plan:
- Defaults; 4 Rx_DV_in pulses spaced 10 cycles apart -> Load_en_out = 0001, 0010, 0100, 1000 in the pulse cycles; En_out=1 the cycle after the 4th pulse.
- Defaults; c_valid_in in EXE at cycle u -> Tx_DV_out at u+1 with sel=0. Tx_Done_in at v -> Tx_DV_out at v+1 with sel=1. Second Tx_Done_in -> Busy_out=0 next cycle with no third pulse.
- Spurious Tx_Done_in in IDLE/EXE, and c_valid_in in LOAD -> no state change, no Tx_DV_out.
- Rx_DV_in during EXE and SEND -> Rx_ovr_out pulses, Load_en_out stays 0. The following frame loads from byte 0.
- OP_BYTES=3, NUM_OPS=3, RES_BYTES=4 -> 9 strobes walk bits 0..8, then 4 TX pulses with sel 0..3.
- RX_TIMEOUT_EN with TIMEOUT_CYC=16; stop after 2 bytes -> Timeout_out pulses and state returns to IDLE. A new frame then strobes bit 0. Separately, RST mid-LOAD -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/uart_frame_controller.sv
// uart_frame_controller: sequences one operand frame from the RX UART into the
// datapath input memory, enables the datapath until it reports a result, then
// streams the result bytes to the TX UART, MSB first.
// Latency: Load_en_out and Rx_ovr_out are combinational with Rx_DV_in. En_out
// rises one cycle after the last byte strobe. Tx_DV_out is registered and
// follows c_valid_in or Tx_Done_in by one cycle.
// Backpressure: none on RX. Bytes arriving in EXE/SEND are dropped and flagged
// on Rx_ovr_out. TX advances only on Tx_Done_in for an outstanding request.
// Optional feature: define RX_TIMEOUT_EN to enable the inter-byte RX timeout
// in LOAD. Without it, Timeout_out is tied low.
// Ports:
//   CLK, RST              clock (rising edge) / async active-high reset
//   Rx_DV_in              received-byte pulse
//   Tx_Done_in            TX UART byte-complete pulse
//   c_valid_in            datapath result valid
//   En_out                datapath enable, high throughout EXE
//   Load_en_out           one-hot input-memory byte strobe
//   Tx_DV_out             TX request pulse
//   Tx_Byte_sel_out       result byte index, 0 = MSB
//   Busy_out              controller is not idle
//   Rx_ovr_out            byte arrived while not loading
//   Timeout_out           RX inter-byte timeout pulse
module uart_frame_controller #(
  parameter int OP_BYTES    = 2,
  parameter int NUM_OPS     = 2,
  parameter int RES_BYTES   = 2,
  parameter int TIMEOUT_CYC = 1000000,
  localparam int IN_BYTES   = NUM_OPS * OP_BYTES,
  localparam int SEL_W      = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Rx_DV_in,
  input  logic                Tx_Done_in,
  input  logic                c_valid_in,
  output logic                En_out,
  output logic [IN_BYTES-1:0] Load_en_out,
  output logic                Tx_DV_out,
  output logic [SEL_W-1:0]    Tx_Byte_sel_out,
  output logic                Busy_out,
  output logic                Rx_ovr_out,
  output logic                Timeout_out
);

  localparam int LD_W = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] EXE  = 2'd2;
  localparam logic [1:0] SEND = 2'd3;

  localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(IN_BYTES - 1);
  localparam logic [SEL_W-1:0] SND_LAST = SEL_W'(RES_BYTES - 1);

  logic [1:0]       state;
  logic [LD_W-1:0]  load_cnt;
  logic [SEL_W-1:0] send_cnt;
  logic             pending;
  logic             tx_dv;
  logic             loading;
  logic             timeout_hit;

  assign loading = (state == IDLE) || (state == LOAD);

`ifdef RX_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TO_W-1:0] idle_cnt;
  logic            to_pulse;

  // A byte on the terminal cycle wins over the timeout.
  assign timeout_hit = (state == LOAD) && !Rx_DV_in &&
                       (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idle_cnt <= '0;
      to_pulse <= 1'b0;
    end else begin
      to_pulse <= timeout_hit;
      // Held at zero outside LOAD so each LOAD entry starts a fresh window.
      if ((state != LOAD) || Rx_DV_in || timeout_hit)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

  assign Timeout_out = to_pulse;
`else
  assign timeout_hit = 1'b0;
  assign Timeout_out = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      load_cnt <= '0;
      send_cnt <= '0;
      pending  <= 1'b0;
      tx_dv    <= 1'b0;
    end else begin
      tx_dv <= 1'b0;
      case (state)
        IDLE: begin
          if (Rx_DV_in) begin
            if (IN_BYTES == 1) begin
              state    <= EXE;
              load_cnt <= '0;
            end else begin
              state    <= LOAD;
              load_cnt <= LD_W'(1);
            end
          end
        end
        LOAD: begin
          if (Rx_DV_in) begin
            if (load_cnt == LD_LAST) begin
              state    <= EXE;
              load_cnt <= '0;
            end else begin
              load_cnt <= load_cnt + LD_W'(1);
            end
          end else if (timeout_hit) begin
            state    <= IDLE;
            load_cnt <= '0;
          end
        end
        EXE: begin
          if (c_valid_in) begin
            state    <= SEND;
            send_cnt <= '0;
            pending  <= 1'b1;
            tx_dv    <= 1'b1;
          end
        end
        SEND: begin
          // Only a completion for an outstanding request advances the stream.
          if (Tx_Done_in && pending) begin
            if (send_cnt == SND_LAST) begin
              state    <= IDLE;
              send_cnt <= '0;
              pending  <= 1'b0;
            end else begin
              send_cnt <= send_cnt + SEL_W'(1);
              tx_dv    <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          load_cnt <= '0;
          send_cnt <= '0;
          pending  <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are gated by RST so every output reads 0 while reset is held,
  // even if the RX UART keeps pulsing.
  always_comb begin
    Load_en_out = '0;
    for (int k = 0; k < IN_BYTES; k++) begin
      Load_en_out[k] = !RST && Rx_DV_in && loading && (load_cnt == LD_W'(k));
    end
  end

  assign Rx_ovr_out      = !RST && Rx_DV_in && !loading;
  assign En_out          = (state == EXE);
  assign Busy_out        = (state != IDLE);
  assign Tx_DV_out       = tx_dv;
  assign Tx_Byte_sel_out = send_cnt;

endmodule
